// File: rtl/lock_disp_pkg.sv
// Shared constants for the lock display scanner: segment patterns
// ({g,f,e,d,c,b,a}, active-low), anode enables and digit-index width.
package lock_disp_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_NUM0  = 7'b1000000;
    localparam logic [6:0] SEG_NUM1  = 7'b1111001;
    localparam logic [6:0] SEG_NUM2  = 7'b0100100;
    localparam logic [6:0] SEG_NUM3  = 7'b0110000;
    localparam logic [6:0] SEG_NUM4  = 7'b0011001;
    localparam logic [6:0] SEG_NUM5  = 7'b0010010;
    localparam logic [6:0] SEG_NUM6  = 7'b0000010;
    localparam logic [6:0] SEG_NUM7  = 7'b1111000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/lock_display_scan_seg7_decode.sv
// Combinational 7-segment decoder. Code digits show a dash for value 0
// (digit not yet entered); the attempts digit shows 0 as a numeral.
module seg7_decode
    import lock_disp_pkg::*;
(
    input  logic [2:0] value_i,
    input  logic       is_code_i,
    output logic [6:0] pattern_o
);

    // Value to active-low segment pattern
    always_comb begin
        pattern_o = SEG_BLANK;
        case (value_i)
            3'd0: pattern_o = is_code_i ? SEG_DASH : SEG_NUM0;
            3'd1: pattern_o = SEG_NUM1;
            3'd2: pattern_o = SEG_NUM2;
            3'd3: pattern_o = SEG_NUM3;
            3'd4: pattern_o = SEG_NUM4;
            3'd5: pattern_o = SEG_NUM5;
            3'd6: pattern_o = SEG_NUM6;
            3'd7: pattern_o = SEG_NUM7;
            default: pattern_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_display_scan.sv
// Four-digit multiplexed display scanner for the code lock: three entered
// code digits plus the remaining-attempts digit. dp lights while open.
// Optional lockout blinking is built when LOCK_DISP_BLINK_EN is defined;
// without it the display stays steady under lockout.
module lock_display_scan
    import lock_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_SLOTS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] disp_1,
    input  logic [2:0] disp_2,
    input  logic [2:0] disp_3,
    input  logic [2:0] disp_N,
    input  logic       lock,
    input  logic       unlock,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_SLOTS < 1) begin : g_bad_blink
        $error("BLINK_SLOTS must be at least 1");
    end

    logic [PRE_W-1:0] pre_q;
    logic [IDX_W-1:0] idx_q;
    logic             slot_tick;
    logic [2:0]       sel_val;
    logic             sel_code;
    logic [3:0]       sel_an;
    logic [6:0]       dec_pat;
    logic             hide;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    // Slot tick on the last prescaler count, i.e. the cycle it wraps to 0
    assign slot_tick = (pre_q == PRE_W'(REFRESH_DIV - 1));

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          pre_q <= '0;
        else if (slot_tick) pre_q <= '0;
        else                pre_q <= pre_q + 1'b1;
    end

    // Digit index holds the digit the next tick will select; starts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          idx_q <= '0;
        else if (slot_tick) idx_q <= idx_q + 1'b1;
    end

    // Select the digit value and anode for the current index
    always_comb begin
        sel_val  = disp_1;
        sel_code = 1'b1;
        sel_an   = AN_DIG0;
        case (idx_q)
            2'd0: begin sel_val = disp_1; sel_code = 1'b1; sel_an = AN_DIG0; end
            2'd1: begin sel_val = disp_2; sel_code = 1'b1; sel_an = AN_DIG1; end
            2'd2: begin sel_val = disp_3; sel_code = 1'b1; sel_an = AN_DIG2; end
            2'd3: begin sel_val = disp_N; sel_code = 1'b0; sel_an = AN_DIG3; end
            default: begin sel_val = disp_1; sel_code = 1'b1; sel_an = AN_DIG0; end
        endcase
    end

    seg7_decode u_decode (
        .value_i   (sel_val),
        .is_code_i (sel_code),
        .pattern_o (dec_pat)
    );

`ifdef LOCK_DISP_BLINK_EN
    localparam int BLK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [BLK_W-1:0] blink_cnt_q;
    blink_phase_e     phase_q;

    // Free-running blink phase: flips every BLINK_SLOTS ticks, independent of
    // lock so a new lockout picks up wherever the phase happens to be
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= PH_VISIBLE;
        end else if (slot_tick) begin
            if (blink_cnt_q == BLK_W'(BLINK_SLOTS - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign hide = lock && (phase_q == PH_HIDDEN);
`else
    assign hide = 1'b0;
`endif

    // Output registers: load once per slot so inputs are held for the slot;
    // lock overrides unlock for the decimal point
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (slot_tick) begin
            an_q  <= sel_an;
            seg_q <= hide ? SEG_BLANK : dec_pat;
            dp_q  <= hide ? 1'b1 : ~(unlock & ~lock);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_lock_display_scan.sv
// Scoreboard bench for lock_display_scan with REFRESH_DIV=4, BLINK_SLOTS=2.
// A reference model pushes the expected {an,seg,dp} every clock; the
// monitor pops and compares on the falling edge. Directed checks cover
// reset, mid-slot input change and mid-slot reset.
module tb_lock_display_scan;

    localparam int DIV = 4;
    localparam int BS  = 2;

    logic       clk;
    logic       reset;
    logic [2:0] disp_1, disp_2, disp_3, disp_N;
    logic       lock, unlock;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;

    lock_display_scan #(.REFRESH_DIV(DIV), .BLINK_SLOTS(BS)) dut (
        .clk    (clk),
        .reset  (reset),
        .disp_1 (disp_1),
        .disp_2 (disp_2),
        .disp_3 (disp_3),
        .disp_N (disp_N),
        .lock   (lock),
        .unlock (unlock),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] num7(input logic [2:0] v);
        case (v)
            3'd0: return 7'b1000000;
            3'd1: return 7'b1111001;
            3'd2: return 7'b0100100;
            3'd3: return 7'b0110000;
            3'd4: return 7'b0011001;
            3'd5: return 7'b0010010;
            3'd6: return 7'b0000010;
            default: return 7'b1111000;
        endcase
    endfunction

    // Reference model
    logic [11:0] sb[$];
    int          m_cnt = 0;
    int          m_idx = 0;
    int          m_bcnt = 0;
    bit          m_hidden = 1'b0;
    logic [3:0]  m_an = 4'b1111;
    logic [6:0]  m_seg = 7'b1111111;
    logic        m_dp = 1'b1;

    always @(posedge clk or posedge reset) begin
        logic [2:0] v;
        bit         code;
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_bcnt = 0; m_hidden = 1'b0;
            m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
            sb.delete();
        end else begin
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                code = 1'b1;
                case (m_idx)
                    0: begin v = disp_1; m_an = 4'b0111; end
                    1: begin v = disp_2; m_an = 4'b1011; end
                    2: begin v = disp_3; m_an = 4'b1101; end
                    default: begin v = disp_N; m_an = 4'b1110; code = 1'b0; end
                endcase
                m_seg = (code && v == 3'd0) ? 7'b0111111 : num7(v);
                m_dp  = !(unlock && !lock);
`ifdef LOCK_DISP_BLINK_EN
                if (lock && m_hidden) begin
                    m_seg = 7'b1111111;
                    m_dp  = 1'b1;
                end
                if (m_bcnt == BS - 1) begin
                    m_bcnt = 0;
                    m_hidden = !m_hidden;
                end else begin
                    m_bcnt++;
                end
`endif
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            sb.push_back({m_an, m_seg, m_dp});
        end
    end

    // Monitor: compare DUT against model away from the active edge
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset) begin
            chk("rst_an", an, 4'b1111);
            chk("rst_seg", seg, 7'b1111111);
            chk("rst_dp", dp, 1'b1);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_an", an, e[11:8]);
            chk("sb_seg", seg, e[7:1]);
            chk("sb_dp", dp, e[0]);
        end
    end

    // Wait (bounded) for an to transition into target
    task automatic wait_an(input logic [3:0] target, input string tag);
        logic [3:0] prev;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == target && prev != target) break;
            prev = an;
        end
        chk(tag, an, target);
    endtask

    // Wait (bounded) for the first slot after reset and check it is index 0
    task automatic first_slot(input string tag);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (an != 4'b1111) break;
        end
        chk(tag, an, 4'b0111);
    endtask

    task automatic run_slots(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    initial begin
        disp_1 = 3'd0; disp_2 = 3'd0; disp_3 = 3'd0; disp_N = 3'd2;
        lock = 1'b0; unlock = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Dashes for empty code digits, attempts numeral
        first_slot("first_slot_idx0");
        chk("first_slot_dash", seg, 7'b0111111);
        run_slots(5);

        // Code entered, open
        @(negedge clk);
        disp_1 = 3'd2; disp_2 = 3'd4; disp_3 = 3'd1; unlock = 1'b1;
        run_slots(8);

        // Mid-slot change on digit 2 waits for its next slot
        wait_an(4'b1011, "reach_idx1");
        chk("idx1_seg4", seg, 7'b0011001);
        disp_2 = 3'd5;
        @(negedge clk);
        chk("hold_mid", seg, 7'b0011001);
        wait_an(4'b1011, "reach_idx1_again");
        chk("upd_mid", seg, 7'b0010010);

        // Lockout, closed
        @(negedge clk);
        unlock = 1'b0; lock = 1'b1;
        run_slots(12);

        // Lock and unlock together: dp dark
        unlock = 1'b1;
        run_slots(8);

        // Random inputs changing at arbitrary points in a slot
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            disp_1 = 3'($urandom_range(0, 7));
            disp_2 = 3'($urandom_range(0, 7));
            disp_3 = 3'($urandom_range(0, 7));
            disp_N = 3'($urandom_range(0, 7));
            lock   = 1'($urandom_range(0, 1));
            unlock = 1'($urandom_range(0, 1));
        end
        run_slots(2);

        // Asynchronous reset mid-slot at index 2
        wait_an(4'b1101, "reach_idx2");
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_an", an, 4'b1111);
        chk("async_rst_seg", seg, 7'b1111111);
        chk("async_rst_dp", dp, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        first_slot("rst_release_idx0");
        run_slots(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
